div32: RTL and testbench
========================

DIV32 -- requirements
Module: div32

Interface
REQ-001 SHALL provide the ports below; reset resetn, synchronous, active-low; clock clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  synchronous active-low reset.
REQ-004 in_valid  input  1  operands offered this cycle.
REQ-005 in_ready  output  1  divider can accept operands; high only in IDLE.
REQ-006 div_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled at accept.
REQ-007 x  input  32  dividend; sampled at accept.
REQ-008 y  input  32  divisor; sampled at accept.
REQ-009 cancel  input  1  abort current operation (pipeline flush).
REQ-010 out_valid  output  1  quotient/remainder valid.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 s  output  32  quotient.
REQ-013 r  output  32  remainder.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; accept = in_valid & in_ready & ~cancel at a rising edge.
REQ-015 On accept SHALL register |x|, |y| (absolute value only when div_signed=1, else raw), quotient sign = x[31]^y[31] & div_signed, remainder sign = x[31] & div_signed, clear 6-bit iteration counter, go CALC.
REQ-016 In CALC SHALL perform one radix-2 restoring step per edge: shift partial remainder left by one, bring in next dividend MSB, trial-subtract 33-bit, set quotient bit to 1 and keep difference if non-negative, else 0 and restore.
REQ-017 SHALL complete exactly 32 CALC steps; after the 32nd step edge state SHALL be DONE and out_valid=1 (uniform latency: out_valid first high 32 edges after the accept edge, for all operands).
REQ-018 Quotient SHALL truncate toward zero; remainder SHALL carry the dividend's sign; sign correction applied before values appear on s/r.
REQ-019 Divisor zero SHALL yield s=0xFFFFFFFF, r=x (original dividend) for both signed and unsigned, with normal latency.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield s=0x80000000, r=0 with no exception.
REQ-021 In DONE, s, r, out_valid SHALL hold stable while out_ready=0.
REQ-022 DONE with out_ready=1 SHALL return to IDLE next edge; out_valid low from that edge; no accept in the same cycle (in_ready low in DONE).
REQ-023 cancel=1 in any state SHALL force IDLE at next edge, drop out_valid, discard result; cancel in IDLE with in_valid=1 SHALL block the accept.
REQ-024 in_valid while in CALC/DONE SHALL be ignored (in_ready=0).
REQ-025 s and r SHALL be 0 whenever out_valid=0.

Reset
REQ-026 resetn=0 at an edge SHALL force IDLE, in_ready=1 after release, out_valid=0, s=0, r=0, counter=0, from any state including mid-CALC.
REQ-027 First accept after reset deassertion SHALL be possible on the first edge with resetn=1.

Verification
REQ-028 Unsigned x=100, y=7 -> after 32 edges out_valid=1, s=14, r=2.
REQ-029 Signed x=0xFFFFFFF9 (-7), y=2 -> s=0xFFFFFFFD, r=0xFFFFFFFF; unsigned 0x80000000/0xFFFFFFFF -> s=0, r=0x80000000; signed same operands -> s=0x80000000, r=0.
REQ-030 y=0, x=0x12345678 both modes -> s=0xFFFFFFFF, r=0x12345678, latency 32.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles in DONE -> s/r/out_valid unchanged, in_ready=0; then out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-032 cancel at CALC step 15 -> IDLE next edge, out_valid never rises; new accept of 9/3 then yields s=3, r=0 at normal latency.
REQ-033 resetn=0 for one edge at CALC step 20 -> all outputs reset values, in_ready=1, no stale out_valid.

Source files
------------

// File: rtl/div32.sv
// Iterative 32-bit radix-2 restoring divider, signed or unsigned, with valid/ready handshake.
// Uniform 32-cycle latency; results are sign-corrected and shown only while out_valid is high.
module div32 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              div_signed,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic              cancel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] s,
    output logic [DATA_W-1:0] r
);

    localparam int                CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;
    logic                div0_q, div0_d;
    // quo_q starts as |dividend| and fills with quotient bits from the LSB as it shifts out.
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;

    logic                accept;
    logic [DATA_W:0]     shifted;
    logic [DATA_W+1:0]   trial;
    logic                trial_ok;

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic              is_signed);
        return (is_signed && v[DATA_W-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                     input logic              neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready & ~cancel;

    // One restoring step: 33-bit trial subtraction, borrow in the top bit.
    assign shifted  = {rem_q, quo_q[DATA_W-1]};
    assign trial    = {1'b0, shifted} - {2'b00, dvs_q};
    assign trial_ok = ~trial[DATA_W+1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        div0_d  = div0_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    quo_d   = magnitude(x, div_signed);
                    dvs_d   = magnitude(y, div_signed);
                    rem_d   = '0;
                    qneg_d  = (x[DATA_W-1] ^ y[DATA_W-1]) & div_signed;
                    rneg_d  = x[DATA_W-1] & div_signed;
                    div0_d  = (y == '0);
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                quo_d = {quo_q[DATA_W-2:0], trial_ok};
                rem_d = trial_ok ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cancel) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
        div0_q <= div0_d;
        quo_q  <= quo_d;
        rem_q  <= rem_d;
        dvs_q  <= dvs_d;
    end

    // Divide-by-zero: the restoring loop already yields |x| as remainder; only the quotient is forced.
    always_comb begin
        out_valid = (state_q == DONE);
        s         = '0;
        r         = '0;
        if (out_valid) begin
            s = div0_q ? '1 : apply_sign(quo_q, qneg_q);
            r = apply_sign(rem_q, rneg_q);
        end
    end

endmodule

// File: tb/tb_div32.sv
// Bench for div32: directed corner cases plus random operands against an arithmetic reference model.
module tb_div32;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        div_signed;
    logic [31:0] x;
    logic [31:0] y;
    logic        cancel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic [31:0] r;

    int n_vec = 0;
    int n_bad = 0;

    div32 dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .div_signed(div_signed),
        .x         (x),
        .y         (y),
        .cancel    (cancel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .r         (r)
    );

    always #5 clk = ~clk;

    // Reference: plain language-level division with the divider's special cases.
    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] rr;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            rr = a;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q  = 32'h8000_0000;
            rr = 32'd0;
        end else if (sg) begin
            q  = 32'($signed(a) / $signed(b));
            rr = 32'($signed(a) % $signed(b));
        end else begin
            q  = a / b;
            rr = a % b;
        end
        return {q, rr};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic sg, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [63:0] e;
        int          lat;
        e = ref_div(sg, a, b);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        div_signed = sg;
        x          = a;
        y          = b;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        div_signed = ~sg;
        x          = $urandom;
        y          = $urandom;
        check("in_ready_busy", 32'(in_ready), 32'd0);
        check("s_zero_busy", s, 32'd0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd32);
        check("quotient", s, e[63:32]);
        check("remainder", r, e[31:0]);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_s", s, e[63:32]);
            check("hold_r", r, e[31:0]);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_s", s, 32'd0);
        check("drain_r", r, 32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic        seen;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        resetn     = 1'b0;
        in_valid   = 1'b0;
        div_signed = 1'b0;
        x          = '0;
        y          = '0;
        cancel     = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_s", s, 32'd0);
        check("rst_r", r, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Accept on the very first edge with resetn high.
        resetn = 1'b1;
        do_op(1'b0, 32'd100, 32'd7, 0);
        check("ref_100_7_q", ref_div(1'b0, 32'd100, 32'd7) >> 32, 32'd14);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(1'b0, 32'h1234_5678, 32'd0, 0);
        do_op(1'b1, 32'h1234_5678, 32'd0, 0);
        do_op(1'b1, 32'hF000_0001, 32'd0, 0);
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 10);

        // cancel together with in_valid in IDLE must block the accept
        x        = 32'd100;
        y        = 32'd7;
        in_valid = 1'b1;
        cancel   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cancel   = 1'b0;
        check("cancel_idle_in_ready", 32'(in_ready), 32'd1);

        // cancel at CALC step 15
        div_signed = 1'b0;
        x          = 32'd50;
        y          = 32'd5;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_in_ready", 32'(in_ready), 32'd1);
        check("cancel_valid", 32'(out_valid), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("cancel_no_valid", 32'(seen), 32'd0);
        do_op(1'b0, 32'd9, 32'd3, 0);

        // reset pulse at CALC step 20
        div_signed = 1'b1;
        x          = 32'hFFFF_FF00;
        y          = 32'd3;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_s", s, 32'd0);
        check("midrst_r", r, 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("midrst_no_valid", 32'(seen), 32'd0);

        for (int k = 0; k < 150; k++) begin
            sg = 1'($urandom % 2);
            a  = $urandom;
            b  = $urandom;
            case ($urandom % 8)
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = $urandom % 16;
                4: b = $urandom % 65536;
                default: ;
            endcase
            do_op(sg, a, b, int'($urandom % 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
